btn_fifo_ctrl: RTL and testbench

//  Board-level FIFO exerciser: two push-button inputs (rd, wr) are synchronised,

---
 rtl/btn_fifo_ctrl_if.sv | 27 ++
 rtl/btn_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_btn_fifo_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/btn_fifo_ctrl_if.sv
// btn_fifo_ctrl_if: board-pin bundle between the push-button/LED side and btn_fifo_ctrl
interface btn_fifo_ctrl_if #(
  parameter int B = 4,
  parameter int W = 4
);
  logic         rd;
  logic         wr;
  logic [B-1:0] wr_data;
  logic [B-1:0] rd_data;
  logic         read;
  logic         write;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   count;
  logic         ovf_err;
  logic         unf_err;
  modport master (
    output rd, wr, wr_data,
    input  rd_data, read, write, full, empty, almost_full, almost_empty, count, ovf_err, unf_err
  );
  modport slave (
    input  rd, wr, wr_data,
    output rd_data, read, write, full, empty, almost_full, almost_empty, count, ovf_err, unf_err
  );
endinterface

// File: rtl/btn_fifo_ctrl.sv
// btn_fifo_ctrl: debounced rd/wr push-buttons driving a fall-through FIFO; define BTN_FIFO_ERR_EN for sticky ovf/unf error flags
module btn_fifo_ctrl #(
  parameter int B      = 4,
  parameter int W      = 4,
  parameter int DB_N   = 19,
  parameter int AF_GAP = 2,
  parameter int AE_GAP = 2
) (
  input logic            clk,
  input logic            reset,
  btn_fifo_ctrl_if.slave bus
);
  localparam logic [W:0] FULL_C = (W+1)'(2**W);
  localparam logic [W:0] AF_C   = (W+1)'(2**W - AF_GAP);
  localparam logic [W:0] AE_C   = (W+1)'(AE_GAP);
  typedef enum logic {STABLE0, STABLE1} db_t;
  logic [1:0]      sync1, sync2;
  db_t             db_st  [2];
  logic [DB_N-1:0] db_cnt [2];
  logic [1:0]      lvl, lvl_d, pulse;
  logic            rd_p, wr_p, do_push, do_pop;
  logic [B-1:0]    mem [2**W];
  logic [W-1:0]    r_ptr, w_ptr;
  logic [W:0]      cnt;
  assign lvl   = {db_st[1] == STABLE1, db_st[0] == STABLE1};
  assign pulse = lvl & ~lvl_d;
  assign rd_p  = pulse[0];
  assign wr_p  = pulse[1];
  // two-flop synchronisers for both raw buttons (bit 0 = rd, bit 1 = wr)
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.wr, bus.rd};
      sync2 <= sync1;
    end
  // debounce FSM per button: level flips only after the synced input disagrees for 2**DB_N cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        db_st[i]  <= STABLE0;
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (sync2[i] == (db_st[i] == STABLE1))
          db_cnt[i] <= '0;
        else if (&db_cnt[i]) begin
          db_st[i]  <= (db_st[i] == STABLE1) ? STABLE0 : STABLE1;
          db_cnt[i] <= '0;
        end else
          db_cnt[i] <= db_cnt[i] + 1'b1;
    end
  // delayed level for rising-edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) lvl_d <= '0;
    else        lvl_d <= lvl;
  // a write into a full FIFO only lands when a read frees the head slot in the same cycle
  assign do_push = wr_p && (cnt != FULL_C || rd_p);
  assign do_pop  = rd_p && cnt != '0;
  // storage is deliberately not reset
  always_ff @(posedge clk)
    if (do_push) mem[w_ptr] <= bus.wr_data;
  // pointers and occupancy
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ptr <= '0;
      w_ptr <= '0;
      cnt   <= '0;
    end else begin
      if (do_push) w_ptr <= w_ptr + 1'b1;
      if (do_pop)  r_ptr <= r_ptr + 1'b1;
      cnt <= (do_push && !do_pop) ? cnt + 1'b1 :
             (do_pop && !do_push) ? cnt - 1'b1 : cnt;
    end
  assign bus.read         = lvl[0];
  assign bus.write        = lvl[1];
  assign bus.count        = cnt;
  assign bus.full         = cnt == FULL_C;
  assign bus.empty        = cnt == '0;
  assign bus.almost_full  = cnt >= AF_C;
  assign bus.almost_empty = cnt <= AE_C;
  assign bus.rd_data      = (cnt == '0) ? '0 : mem[r_ptr];
`ifdef BTN_FIFO_ERR_EN
  logic ovf_q, unf_q;
  // sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_p && !rd_p && cnt == FULL_C) ovf_q <= 1'b1;
      if (rd_p && cnt == '0)              unf_q <= 1'b1;
    end
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;
`else
  assign bus.ovf_err = 1'b0;
  assign bus.unf_err = 1'b0;
`endif
endmodule

// File: tb/tb_btn_fifo_ctrl.sv
// tb_btn_fifo_ctrl: table, hand-written and random checks of btn_fifo_ctrl against a queue model
module tb_btn_fifo_ctrl;
  localparam int B = 4, W = 2, DB_N = 3, AF_GAP = 1, AE_GAP = 1, DEPTH = 4;
`ifdef BTN_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0, fails = 0;
  logic [B-1:0] q[$];
  bit m_ovf, m_unf;
  typedef struct {bit r; bit w; logic [3:0] d; logic [12:0] exp;} vec_t;
  vec_t tbl [10];
  btn_fifo_ctrl_if #(.B(B), .W(W)) bus ();
  btn_fifo_ctrl #(.B(B), .W(W), .DB_N(DB_N), .AF_GAP(AF_GAP), .AE_GAP(AE_GAP))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  function automatic logic [12:0] mk(int c, int d, bit f, bit e, bit af, bit ae, bit ov, bit un);
    return {3'(c), 4'(d), f, e, af, ae, ov, un};
  endfunction
  function automatic logic [12:0] dut_vec();
    return {bus.count, bus.rd_data, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.ovf_err, bus.unf_err};
  endfunction
  function automatic logic [12:0] model_vec();
    int n = q.size();
    return mk(n, (n != 0) ? int'(q[0]) : 0, n == DEPTH, n == 0, n >= DEPTH - AF_GAP, n <= AE_GAP,
              m_ovf & ERR, m_unf & ERR);
  endfunction
  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask
  task automatic model_op(input bit r, input bit w, input logic [3:0] d);
    if (r && q.size() == 0) m_unf = 1;
    if (w && !r && q.size() == DEPTH) m_ovf = 1;
    if (r && w) begin
      if (q.size() != 0) void'(q.pop_front());
      q.push_back(d);
    end else if (w) begin
      if (q.size() < DEPTH) q.push_back(d);
    end else if (r && q.size() != 0)
      void'(q.pop_front());
  endtask
  task automatic do_op(input bit r, input bit w, input logic [3:0] d);
    bus.rd = r;
    bus.wr = w;
    bus.wr_data = d;
    repeat (12) tick();
    bus.rd = 0;
    bus.wr = 0;
    repeat (12) tick();
    model_op(r, w, d);
  endtask
  task automatic hard_reset();
    reset = 0;
    tick();
    reset = 1;
    tick();
    model_reset();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    tbl[0] = '{0, 1, 4'hA, mk(1, 4'hA, 0, 0, 0, 1, 0, 0)};
    tbl[1] = '{0, 1, 4'hB, mk(2, 4'hA, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{0, 1, 4'hC, mk(3, 4'hA, 0, 0, 1, 0, 0, 0)};
    tbl[3] = '{0, 1, 4'hD, mk(4, 4'hA, 1, 0, 1, 0, 0, 0)};
    tbl[4] = '{0, 1, 4'hE, mk(4, 4'hA, 1, 0, 1, 0, ERR, 0)};
    tbl[5] = '{1, 0, 4'h0, mk(3, 4'hB, 0, 0, 1, 0, ERR, 0)};
    tbl[6] = '{1, 0, 4'h0, mk(2, 4'hC, 0, 0, 0, 0, ERR, 0)};
    tbl[7] = '{1, 0, 4'h0, mk(1, 4'hD, 0, 0, 0, 1, ERR, 0)};
    tbl[8] = '{1, 0, 4'h0, mk(0, 0, 0, 1, 0, 1, ERR, 0)};
    tbl[9] = '{1, 0, 4'h0, mk(0, 0, 0, 1, 0, 1, ERR, ERR)};
    bus.rd = 0;
    bus.wr = 0;
    bus.wr_data = 0;
    model_reset();
    repeat (3) tick();
    check("reset_flags", dut_vec(), mk(0, 0, 0, 1, 0, 1, 0, 0));
    check("reset_levels", {bus.read, bus.write}, 0);
    reset = 1;
    tick();
    for (int k = 0; k < 40; k++) begin
      bus.wr = ((k / 3) % 2) == 0;
      bus.wr_data = 4'h6;
      tick();
    end
    bus.wr = 1;
    n = 0;
    while (!bus.write && n < 50) begin
      tick();
      n++;
    end
    check("bounce_latency", n, 10);
    repeat (2) tick();
    bus.wr = 0;
    repeat (12) tick();
    check("bounce_one_push", dut_vec(), mk(1, 6, 0, 0, 0, 1, 0, 0));
    hard_reset();
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].r, tbl[i].w, tbl[i].d);
      check($sformatf("table_%0d", i), dut_vec(), tbl[i].exp);
    end
    do_op(1, 1, 4'h7);
    check("both_empty_count", bus.count, 1);
    check("both_empty_data", bus.rd_data, 4'h7);
    do_op(0, 1, 4'h1);
    do_op(0, 1, 4'h2);
    do_op(0, 1, 4'h3);
    check("prefill_full", dut_vec(), model_vec());
    do_op(1, 1, 4'h9);
    check("both_full_count", bus.count, 4);
    check("both_full_head", bus.rd_data, 4'h1);
    check("both_full_model", dut_vec(), model_vec());
    for (int i = 0; i < 48; i++) begin
      int op = $urandom_range(0, 5);
      logic [3:0] d = 4'($urandom_range(0, 15));
      do_op(op >= 3, op <= 2 || op == 5, d);
      check($sformatf("rand_%0d", i), dut_vec(), model_vec());
    end
    hard_reset();
    do_op(0, 1, 4'h3);
    do_op(0, 1, 4'h4);
    do_op(0, 1, 4'h5);
    check("pre_reset_count", bus.count, 3);
    bus.wr = 1;
    bus.wr_data = 4'hF;
    repeat (5) tick();
    reset = 0;
    #1;
    check("async_reset_flags", dut_vec(), mk(0, 0, 0, 1, 0, 1, 0, 0));
    check("async_reset_levels", {bus.read, bus.write}, 0);
    bus.wr = 0;
    repeat (2) tick();
    reset = 1;
    repeat (30) tick();
    check("released_no_push", bus.count, 0);
    bus.wr = 1;
    repeat (5) tick();
    reset = 0;
    repeat (2) tick();
    reset = 1;
    repeat (30) tick();
    check("held_one_push_count", bus.count, 1);
    check("held_one_push_data", bus.rd_data, 4'hF);
    bus.wr = 0;
    repeat (14) tick();
    check("held_no_second_push", bus.count, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
